// File: rtl/line_buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl_pkg
// Shared constants and types for the 3x3 filter front end: line geometry,
// pixel/window widths, fill-level thresholds, read FSM state encoding and a
// column wrap helper used by both the controller and the line buffers.
// -----------------------------------------------------------------------------
package line_buffer_ctrl_pkg;

  // Line geometry. LINE_WIDTH is also the depth of each line_buffer, so a
  // read pointer returns to column 0 after exactly one line.
  localparam int LINE_WIDTH = 512;
  localparam int NUM_LINES  = 4;

  // Data widths.
  localparam int PIX_W  = 8;
  localparam int TAP_W  = 3 * PIX_W;   // three horizontal taps of one line
  localparam int WIN_W  = 72;          // 3x3 window
  localparam int COL_W  = $clog2(LINE_WIDTH);
  localparam int SEL_W  = 2;           // selects one of NUM_LINES buffers
  localparam int FILL_W = 12;          // holds 0..NUM_LINES*LINE_WIDTH

  // Fill-level thresholds.
  localparam logic [FILL_W-1:0] FILL_MAX    = FILL_W'(NUM_LINES * LINE_WIDTH);
  localparam logic [FILL_W-1:0] READ_THRESH = FILL_W'(3 * LINE_WIDTH);

  localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(LINE_WIDTH - 1);

  // Read FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Column arithmetic modulo LINE_WIDTH (correct for non power-of-two widths).
  function automatic logic [COL_W-1:0] col_add(input logic [COL_W-1:0] col,
                                               input int unsigned      inc);
    int unsigned s;
    s = 32'(col) + inc;
    if (s >= LINE_WIDTH) begin
      s = s - LINE_WIDTH;
    end
    return COL_W'(s);
  endfunction

endpackage : line_buffer_ctrl_pkg

// File: rtl/line_buffer_ctrl_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One line of pixel storage (LINE_WIDTH entries) with independent write and
// read pointers. The read side presents three horizontally adjacent taps
// combinationally: {col rd_ptr, col rd_ptr+1, col rd_ptr+2}, wrapping modulo
// LINE_WIDTH, with the lowest column in the most significant byte.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high pointer clear (memory kept)
//   input_valid  in   write pixel_in at the write pointer, advance it
//   pixel_in     in   pixel to store
//   read_data    in   advance the read pointer by one column
//   taps_out     out  {p0, p1, p2} at the current read column
// -----------------------------------------------------------------------------
module line_buffer
  import line_buffer_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             input_valid,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             read_data,
  output logic [TAP_W-1:0] taps_out
);

  logic [PIX_W-1:0] r_mem [LINE_WIDTH];
  logic [COL_W-1:0] r_wr_ptr;
  logic [COL_W-1:0] r_rd_ptr;
  logic [COL_W-1:0] w_rd_ptr_p1;
  logic [COL_W-1:0] w_rd_ptr_p2;

  // Storage has no reset; stale contents are never presented as valid data.
  always_ff @(posedge clk) begin
    if (input_valid) begin
      r_mem[r_wr_ptr] <= pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (input_valid) begin
        r_wr_ptr <= col_add(r_wr_ptr, 1);
      end
      if (read_data) begin
        r_rd_ptr <= col_add(r_rd_ptr, 1);
      end
    end
  end

  // The last two columns of a line pick up taps from columns 0 and 1.
  assign w_rd_ptr_p1 = col_add(r_rd_ptr, 1);
  assign w_rd_ptr_p2 = col_add(r_rd_ptr, 2);

  assign taps_out = {r_mem[r_rd_ptr], r_mem[w_rd_ptr_p1], r_mem[w_rd_ptr_p2]};

endmodule : line_buffer

// File: rtl/line_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// line_buffer_ctrl
// Front end of the 3x3 filter path. Rotates the raster pixel stream across
// four line buffers and, once three full lines are held, streams 3x3 windows
// to the convolution stage under valid/ready. line_done pulses each time a
// line slot is released so the host can send another line.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous, active-low reset
//   pixel_in        in   8-bit raster pixel
//   pixel_in_valid  in   pixel_in valid this cycle
//   window_out      out  {top p0,p1,p2, mid p0,p1,p2, bot p0,p1,p2};
//                        top = oldest line, p0 = lowest column
//   window_valid    out  window_out valid
//   window_ready    in   downstream accepts the window
//   line_done       out  one-cycle pulse after the last window of a line
//   fill_count      out  pixels buffered and not yet consumed (0..2048)
//   overflow        out  sticky: a write arrived while completely full
//
// Read FSM:
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | fewer than three lines buffered (or one-cycle gap between lines)
//   READ  | presenting windows for line rd_sel, column rd_cnt
// -----------------------------------------------------------------------------
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              pixel_in_valid,
  output logic [WIN_W-1:0]  window_out,
  output logic              window_valid,
  input  logic              window_ready,
  output logic              line_done,
  output logic [FILL_W-1:0] fill_count,
  output logic              overflow
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [COL_W-1:0]  r_wr_cnt;
  logic [SEL_W-1:0]  r_wr_sel;
  logic [COL_W-1:0]  r_rd_cnt;
  logic [SEL_W-1:0]  r_rd_sel;
  logic [FILL_W-1:0] r_fill_count;
  logic              r_line_done;
  logic              r_overflow;

  logic              w_lb_rst;
  logic              w_wr_accept;
  logic              w_wr_drop;
  logic              w_xfer;
  logic              w_last_col;
  logic [SEL_W-1:0]  w_sel_mid;
  logic [SEL_W-1:0]  w_sel_bot;
  logic [SEL_W-1:0]  w_sel_free;
  logic [TAP_W-1:0]  w_taps [NUM_LINES];

  // ---------------------------------------------------------------------------
  // Handshake and pointer helpers
  // ---------------------------------------------------------------------------
  assign w_lb_rst    = ~rst;
  assign w_wr_accept = pixel_in_valid && (r_fill_count < FILL_MAX);
  assign w_wr_drop   = pixel_in_valid && !w_wr_accept;
  assign w_xfer      = window_valid && window_ready;
  assign w_last_col  = (r_rd_cnt == LAST_COL);

  // The three read lines are consecutive mod 4; the fourth is the write slot.
  assign w_sel_mid   = r_rd_sel + 2'd1;
  assign w_sel_bot   = r_rd_sel + 2'd2;
  assign w_sel_free  = r_rd_sel + 2'd3;

  // ---------------------------------------------------------------------------
  // Line buffer bank
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_lb
    logic w_wr_en;
    logic w_rd_en;

    assign w_wr_en = w_wr_accept && (r_wr_sel == SEL_W'(g));
    assign w_rd_en = w_xfer && (w_sel_free != SEL_W'(g));

    line_buffer u_line_buffer (
      .clk         (clk),
      .rst         (w_lb_rst),
      .input_valid (w_wr_en),
      .pixel_in    (pixel_in),
      .read_data   (w_rd_en),
      .taps_out    (w_taps[g])
    );
  end

  // 4:3 rotation, oldest line on top.
  assign window_out = {w_taps[r_rd_sel], w_taps[w_sel_mid], w_taps[w_sel_bot]};

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // window_ready is used directly here (rather than w_xfer) so the block does
  // not read back its own window_valid output.
  always_comb begin
    w_state_nxt  = r_state;
    window_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_fill_count >= READ_THRESH) begin
          w_state_nxt = READ;
        end
      end
      READ: begin
        window_valid = 1'b1;
        if (window_ready && w_last_col) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write pointer: column count within the line plus buffer select
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt <= '0;
      r_wr_sel <= '0;
    end else if (w_wr_accept) begin
      if (r_wr_cnt == LAST_COL) begin
        r_wr_cnt <= '0;
        r_wr_sel <= r_wr_sel + 2'd1;
      end else begin
        r_wr_cnt <= r_wr_cnt + COL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pointer and end-of-line pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt    <= '0;
      r_rd_sel    <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= w_xfer && w_last_col;
      if (w_xfer) begin
        if (w_last_col) begin
          r_rd_cnt <= '0;
          r_rd_sel <= r_rd_sel + 2'd1;
        end else begin
          r_rd_cnt <= r_rd_cnt + COL_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fill level and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_count <= '0;
    end else begin
      case ({w_wr_accept, w_xfer})
        2'b10:   r_fill_count <= r_fill_count + FILL_W'(1);
        2'b01:   r_fill_count <= r_fill_count - FILL_W'(1);
        default: r_fill_count <= r_fill_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_wr_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign line_done  = r_line_done;
  assign fill_count = r_fill_count;
  assign overflow   = r_overflow;

endmodule : line_buffer_ctrl

// File: tb/tb_line_buffer_ctrl.sv
`timescale 1ns/1ps
module tb_line_buffer_ctrl;

  localparam int LW = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        pixel_in_valid = 1'b0;
  logic        window_ready = 1'b0;
  logic [71:0] window_out;
  logic        window_valid;
  logic        line_done;
  logic [11:0] fill_count;
  logic        overflow;

  always #5 clk = ~clk;

  line_buffer_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .window_out     (window_out),
    .window_valid   (window_valid),
    .window_ready   (window_ready),
    .line_done      (line_done),
    .fill_count     (fill_count),
    .overflow       (overflow)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: history of accepted pixels plus read position.
  logic [7:0]  hist [0:16383];
  int          m_seq, m_wr, m_fill, m_line, m_col;
  bit          m_read, m_ovf;
  int          pat;
  bit          prev_hold;
  logic [71:0] prev_win;
  int          ld_seen;
  int          max_fill;

  typedef struct {
    bit rst_before;
    int pat;
    bit v;
    bit r;
    int n;
    int exp_fill;
    bit exp_valid;
    bit exp_ld;
    bit exp_ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input int seq, input int p);
    if (p == 0) return 8'(seq);
    return 8'(seq + (seq / LW) * 37);
  endfunction

  // Expected window; taps past the end of the line are masked out.
  task automatic model_window(output logic [71:0] w, output logic [71:0] m);
    w = '0;
    m = '0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        int c;
        int pos;
        c   = m_col + j;
        pos = 71 - (r * 3 + j) * 8;
        if (c < LW) begin
          w[pos -: 8] = hist[(m_line + r) * LW + c];
          m[pos -: 8] = 8'hFF;
        end
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic do_cycle(input bit v, input bit r);
    bit          acc;
    bit          xfer;
    bit          ld_exp;
    logic [71:0] ew;
    logic [71:0] em;
    pixel_in_valid = v;
    window_ready   = r;
    pixel_in       = pix_of(m_seq, pat);
    #2;
    check("window_valid", window_valid, m_read);
    if (m_read) begin
      model_window(ew, em);
      check("window_out", window_out & em, ew & em);
      if (prev_hold) check("window_hold", window_out, prev_win);
    end
    prev_hold = m_read && !r;
    prev_win  = window_out;
    xfer = m_read && r;
    acc  = v && (m_fill < 2048);
    @(posedge clk);
    if (acc) begin
      if (m_wr < 16384) hist[m_wr] = pixel_in;
      m_wr++;
    end
    if (v) m_seq++;
    if (v && !acc) m_ovf = 1'b1;
    ld_exp = 1'b0;
    if (!m_read) begin
      if (m_fill >= 1536) m_read = 1'b1;
    end else if (xfer) begin
      if (m_col == LW - 1) begin
        m_col  = 0;
        m_line++;
        m_read = 1'b0;
        ld_exp = 1'b1;
      end else begin
        m_col++;
      end
    end
    m_fill = m_fill + (acc ? 1 : 0) - (xfer ? 1 : 0);
    #1;
    check("fill_count", fill_count, m_fill);
    check("line_done", line_done, ld_exp);
    check("overflow", overflow, m_ovf);
    if (line_done) ld_seen++;
    if (int'(fill_count) > max_fill) max_fill = int'(fill_count);
  endtask

  // Hold reset across three clock edges, check cleared outputs, release.
  task automatic do_reset();
    rst            = 1'b0;
    pixel_in_valid = 1'b0;
    window_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_window_valid", window_valid, 0);
    check("rst_line_done", line_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fill_count", fill_count, 0);
    rst       = 1'b1;
    m_seq     = 0;
    m_wr      = 0;
    m_fill    = 0;
    m_line    = 0;
    m_col     = 0;
    m_read    = 1'b0;
    m_ovf     = 1'b0;
    prev_hold = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t t;
    t = vecs[i];
    if (t.rst_before) do_reset();
    pat = t.pat;
    for (int k = 0; k < t.n; k++) do_cycle(t.v, t.r);
    check($sformatf("vec%0d_fill", i), fill_count, t.exp_fill);
    check($sformatf("vec%0d_valid", i), window_valid, t.exp_valid);
    check($sformatf("vec%0d_line_done", i), line_done, t.exp_ld);
    check($sformatf("vec%0d_overflow", i), overflow, t.exp_ovf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    //              rst pat v  r  n     fill  vld ld ovf
    vecs[0]  = '{1'b0, 0, 1'b1, 1'b1, 1535, 1535, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 0, 1'b1, 1'b1,    1, 1536, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 0, 1'b0, 1'b0,    1, 1536, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 0, 1'b0, 1'b1,  511, 1025, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 0, 1'b0, 1'b1,    1, 1024, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 0, 1'b0, 1'b1,    1, 1024, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1, 1'b1, 1'b0, 2048, 2048, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1, 1'b1, 1'b0,    1, 2048, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1, 1'b1, 1'b0,    3, 2048, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1, 1'b0, 1'b1,  512, 1536, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1, 1'b0, 1'b0,    1, 1536, 1'b1, 1'b0, 1'b1};

    @(posedge clk);
    #1;
    do_reset();

    // Mid-stream reset.
    pat = 0;
    for (int k = 0; k < 100; k++) do_cycle(1'b1, 1'b1);
    do_reset();

    // Fill and single-line drain.
    for (int i = 0; i < 6; i++) begin
      run_vec(i);
      if (i == 2) check("first_window", window_out, 72'h000102000102000102);
    end

    // Backpressure: one more line in, one line out, random ready.
    pat     = 1;
    ld_seen = 0;
    for (int k = 0; k < LW; k++) do_cycle(1'b1, $urandom_range(0, 1) == 1);
    guard = 0;
    while (ld_seen < 1 && guard < 4000) begin
      do_cycle(1'b0, $urandom_range(0, 1) == 1);
      guard++;
    end
    check("bp_lines_done", ld_seen, 1);
    check("bp_fill", fill_count, 1024);

    // Streaming: continuous writes and ready over eight lines.
    ld_seen  = 0;
    max_fill = 0;
    for (int k = 0; k < 4616; k++) do_cycle(1'b1, 1'b1);
    check("stream_lines_done", ld_seen, 8);
    check("stream_fill", fill_count, 1544);
    check("stream_last_line_done", line_done, 1);
    check("stream_max_fill_ok", max_fill <= 2048, 1);

    // Overflow, drain of untouched line 0, back-to-back restart.
    for (int i = 6; i < 11; i++) run_vec(i);

    // Reset clears sticky overflow and an active read.
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_line_buffer_ctrl
